// File: rtl/single_port_ram.sv
// single_port_ram: sync single-port RAM, write-first registered q; clk, rst (async clear of q), data/addr/we in, q out
module single_port_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] q
);
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
  always_ff @(posedge clk)
    if (!rst && we) mem[addr] <= data;
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else q <= we ? data : mem[addr];
endmodule

// File: tb/tb_single_port_ram.sv
// tb_single_port_ram: directed vectors checking reset, write-first, read latency and a full sweep
module tb_single_port_ram;
  logic clk = 0, rst = 1, we = 0;
  logic [7:0] data = 0;
  logic [5:0] addr = 0;
  logic [7:0] q;
  int checks = 0, failures = 0;
  single_port_ram dut (.clk(clk), .rst(rst), .data(data), .addr(addr), .we(we), .q(q));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask
  task automatic access(input logic w, input logic [5:0] a, input logic [7:0] d);
    we = w;
    addr = a;
    data = d;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1 check("reset_q", q, 8'h00);
    @(posedge clk);
    #1 check("reset_hold", q, 8'h00);
    rst = 0;
    access(0, 3, 8'hEE); check("unwritten_3", q, 8'h00);
    access(1, 0, 8'h01); check("wr0", q, 8'h01);
    access(1, 1, 8'h02); check("wr1_write_first", q, 8'h02);
    access(1, 2, 8'h03); check("wr2", q, 8'h03);
    access(0, 0, 8'hFF); check("rd0", q, 8'h01);
    access(0, 1, 8'hFF); check("rd1", q, 8'h02);
    access(0, 2, 8'hFF); check("rd2", q, 8'h03);
    access(1, 1, 8'h04); check("overwrite1", q, 8'h04);
    access(0, 1, 8'h00); check("rd1_new", q, 8'h04);
    access(0, 3, 8'h00); check("rd3_zero", q, 8'h00);
    access(1, 1, 8'h11); access(1, 1, 8'h22);
    access(0, 1, 8'h00); check("last_write_wins", q, 8'h22);
    rst = 1;
    #1 check("async_clear", q, 8'h00);
    access(1, 2, 8'hFF); check("rst_blocks_q", q, 8'h00);
    access(1, 0, 8'h77); check("rst_hold_q", q, 8'h00);
    rst = 0;
    access(0, 2, 8'h00); check("rd2_after_rst", q, 8'h03);
    access(0, 0, 8'h00); check("rd0_after_rst", q, 8'h01);
    for (int i = 0; i < 64; i++) access(1, 6'(i), 8'(i) ^ 8'hA5);
    for (int i = 0; i < 64; i++) begin
      access(0, 6'(i), 8'h00);
      check($sformatf("sweep_%0d", i), q, 8'(i) ^ 8'hA5);
    end
    access(0, 63, 8'h00); check("sweep_63_const", q, 8'h9A);
    access(0, 0, 8'h00); check("sweep_0_const", q, 8'hA5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/single_port_ram.md
Name: single_port_ram

Overview:
- Synchronous single-port RAM. One shared address bus serves both reads and writes.
- Default geometry is 64 words x 8 bits.
- Writes are synchronous, and the read data output is registered.
- Used as a general-purpose on-chip scratch memory. One access per clock cycle.

Parameters:
- DATA_WIDTH, 8, width of each word and of the data/q buses.
- ADDR_WIDTH, 6, address bus width.
- DEPTH, 2**ADDR_WIDTH (64), number of words. Must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  clock; all state changes on its rising edge except reset.
- rst  input  1  asynchronous, active-high reset.
- data  input  DATA_WIDTH  write data.
- addr  input  ADDR_WIDTH  word address for both read and write.
- we  input  1  write enable, active high.
- q  output  DATA_WIDTH  registered read data.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Storage: array mem[0..DEPTH-1] of DATA_WIDTH bits.
  - Every word is initialised to 0 at time zero, so reading never-written locations returns 0.
- Reset:
  - rst high forces q to 0 immediately, without waiting for a clock edge.
  - q stays 0 while rst is high.
  - Memory contents are NOT modified by reset.
  - Writes are blocked while rst is high.
- Write, rising clk edge with rst=0 and we=1:
  - mem[addr] <= data.
  - q <= data on the same edge (write-first / write-through).
  - The output reflects the new word, not the old contents.
- Read, rising clk edge with rst=0 and we=0:
  - q <= mem[addr].
  - Latency is 1 cycle: the address presented before edge N appears on q after edge N.
  - q holds its value until the next rising edge.
- No handshake. An access occurs on every edge.
  - q always updates on every edge when rst=0, regardless of we.
- Address range: addr is always in range, since DEPTH = 2**ADDR_WIDTH.
  - No wrap-around logic and no error flag.
- Back-to-back access:
  - A write to A followed by a read of A on the next edge returns the newly written value.
  - Consecutive writes to the same address: the last one wins.
- Reset deasserted:
  - The first rising edge after rst falls performs a normal access.
  - Memory retains all data written before the reset.
- Inputs are sampled only at the rising edge. data is don't-care when we=0.
- Implementation must infer block/distributed RAM:
  - No reset on the array.
  - Output register with async clear.

Test Plan:
- Power-up and reset: assert rst, then release. q=0x00. Read addr 3 with no prior writes -> q=0x00 one cycle later.
- Basic write/read: write 0x01@0, 0x02@1, 0x03@2 (we=1, one per cycle). Then we=0 and read 0, 1, 2 -> q=0x01, 0x02, 0x03 on successive cycles.
- Write-first output: during the write of 0x02@1, q=0x02 after that edge.
- Overwrite then read: write 0x04@1, then read addr 1 -> q=0x04. Then read addr 3 (never written) -> q=0x00.
- Asynchronous reset mid-operation: after the writes above, assert rst between clock edges -> q=0x00 immediately. Pulse a write with we=1 while rst is high -> no memory change. After release, read addr 2 -> q=0x03.
- Full sweep: write mem[i]=i XOR 0xA5 for i=0..63, then read all 64 -> each q matches, including addr 63 (0x9A) and addr 0 (0xA5).
